// File: rtl/mul_u_if.sv
// Execute-stage multiply handshake: level-held start/done plus operands and product halves.
interface mul_u_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  start;
    logic                  done;
    logic                  busy;
    logic [DATA_WIDTH-1:0] mul_src_data1;
    logic [DATA_WIDTH-1:0] mul_src_data2;
    logic [DATA_WIDTH-1:0] mul_result_lo;
    logic [DATA_WIDTH-1:0] mul_result_hi;

    modport master (
        output start, mul_src_data1, mul_src_data2,
        input  done, busy, mul_result_lo, mul_result_hi
    );

    modport slave (
        input  start, mul_src_data1, mul_src_data2,
        output done, busy, mul_result_lo, mul_result_hi
    );
endinterface

// File: rtl/mul_u.sv
// Unsigned iterative shift-add multiplier, one multiplier bit per cycle, full 2*DATA_WIDTH product.
// Optional MUL_U_FAST_PATH_EN: operands of 0 or 1 complete combinationally in the start cycle.
module mul_u #(
    parameter int DATA_WIDTH   = 32,
    parameter int D_DATA_WIDTH = DATA_WIDTH * 2,
    parameter int CNT_WIDTH    = 6
) (
    input logic   cpu_clk,
    input logic   cpu_rstn,
    mul_u_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    state_e                  state_q, state_d;
    logic                    start_q;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic [D_DATA_WIDTH:0]   acc_q, acc_d;
    logic                    start_rising;
    logic [DATA_WIDTH:0]     hi_sum;
    logic                    fastpath_hit;
    logic [D_DATA_WIDTH-1:0] fast_prod;
    logic [D_DATA_WIDTH-1:0] prod;

    assign start_rising = bus.start & ~start_q;

`ifdef MUL_U_FAST_PATH_EN
    logic src1_zero, src2_zero, src1_one, src2_one;
    assign src1_zero    = (bus.mul_src_data1 == '0);
    assign src2_zero    = (bus.mul_src_data2 == '0);
    assign src1_one     = (bus.mul_src_data1 == DATA_WIDTH'(1));
    assign src2_one     = (bus.mul_src_data2 == DATA_WIDTH'(1));
    assign fastpath_hit = bus.start & (src1_zero | src2_zero | src1_one | src2_one);
    assign fast_prod    = (src1_zero | src2_zero) ? '0 :
                          src1_one ? D_DATA_WIDTH'(bus.mul_src_data2) :
                                     D_DATA_WIDTH'(bus.mul_src_data1);
`else
    assign fastpath_hit = 1'b0;
    assign fast_prod    = '0;
`endif

    // Upper half plus carry bit; acc[0] is the multiplier bit consumed this cycle.
    assign hi_sum = acc_q[0] ? ({1'b0, acc_q[D_DATA_WIDTH-1:DATA_WIDTH]} + {1'b0, bus.mul_src_data1})
                             : acc_q[D_DATA_WIDTH:DATA_WIDTH];

    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            state_q <= IDLE;
            start_q <= 1'b0;
            cnt_q   <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            start_q <= bus.start;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        unique case (state_q)
            IDLE: begin
                if (start_rising && !fastpath_hit) begin
                    acc_d   = {{(D_DATA_WIDTH + 1 - DATA_WIDTH){1'b0}}, bus.mul_src_data2};
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (!bus.start) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    // Add-then-shift folded into one update: carry lands in bit D_DATA_WIDTH-1.
                    acc_d = {1'b0, hi_sum, acc_q[DATA_WIDTH-1:1]};
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_WIDTH'(DATA_WIDTH - 1))
                        state_d = DONE;
                end
            end
            DONE: begin
                if (!bus.start) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign prod = (state_q == DONE) ? acc_q[D_DATA_WIDTH-1:0] :
                  fastpath_hit      ? fast_prod : '0;

    assign bus.done          = (state_q == DONE) | fastpath_hit;
    assign bus.busy          = (state_q == BUSY);
    assign bus.mul_result_lo = prod[DATA_WIDTH-1:0];
    assign bus.mul_result_hi = prod[D_DATA_WIDTH-1:DATA_WIDTH];
endmodule

// File: tb/tb_mul_u.sv
// Directed-vector bench for mul_u: reset, latency, carry, fast-path operands, abort, back-to-back.
module tb_mul_u;
    logic clk;
    logic rstn;
    int   n_vec;
    int   n_err;

`ifdef MUL_U_FAST_PATH_EN
    localparam int FP_CYC = 0;
`else
    localparam int FP_CYC = 33;
`endif

    mul_u_if #(.DATA_WIDTH(32)) bus ();

    mul_u #(.DATA_WIDTH(32)) dut (
        .cpu_clk (clk),
        .cpu_rstn(rstn),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Called just after a rising edge; that cycle is cycle 0 of the op.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input int exp_cyc, input logic [63:0] exp_p);
        int          dcyc;
        int          bcnt;
        logic [63:0] p;
        bus.mul_src_data1 = a;
        bus.mul_src_data2 = b;
        bus.start         = 1'b1;
        dcyc = -1;
        bcnt = 0;
        p    = '0;
        for (int c = 0; c <= 40; c++) begin
            @(negedge clk);
            if (bus.busy) bcnt++;
            if (bus.done) begin
                dcyc = c;
                p    = {bus.mul_result_hi, bus.mul_result_lo};
                break;
            end
        end
        chk({tag, ".done_cyc"}, 64'(dcyc), 64'(exp_cyc));
        chk({tag, ".lo"}, {32'h0, p[31:0]}, {32'h0, exp_p[31:0]});
        chk({tag, ".hi"}, {32'h0, p[63:32]}, {32'h0, exp_p[63:32]});
        chk({tag, ".busy_cyc"}, 64'(bcnt), (exp_cyc == 0) ? 64'd0 : 64'd32);
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk({tag, ".done_hold"}, 64'(bus.done), (exp_cyc == 0) ? 64'd0 : 64'd1);
        @(posedge clk); #1;
        chk({tag, ".done_fall"}, 64'(bus.done), 64'd0);
    endtask

    initial begin
        int dseen;
        n_vec = 0;
        n_err = 0;
        rstn              = 1'b0;
        bus.start         = 1'b0;
        bus.mul_src_data1 = '0;
        bus.mul_src_data2 = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst.done", 64'(bus.done), 64'd0);
        chk("rst.busy", 64'(bus.busy), 64'd0);
        chk("rst.lo", 64'(bus.mul_result_lo), 64'd0);
        chk("rst.hi", 64'(bus.mul_result_hi), 64'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;

        run_op("basic", 32'h0000_1234, 32'h0000_5678, 33, 64'h0000_0000_0626_0060);
        run_op("carry", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 64'hFFFF_FFFE_0000_0001);
        run_op("fp_zero", 32'h0000_0000, 32'hDEAD_BEEF, FP_CYC, 64'h0);
        run_op("fp_one", 32'h0000_0001, 32'h8000_0000, FP_CYC, 64'h0000_0000_8000_0000);

        // Abort: start high cycles 0..9, low from cycle 10.
        dseen = 0;
        bus.mul_src_data1 = 32'h0000_1234;
        bus.mul_src_data2 = 32'h0000_5678;
        bus.start         = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.done) dseen++;
        end
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(negedge clk);
        if (bus.done) dseen++;
        chk("abort.busy_c10", 64'(bus.busy), 64'd1);
        @(posedge clk); #1;
        chk("abort.busy_c11", 64'(bus.busy), 64'd0);
        chk("abort.lo", 64'(bus.mul_result_lo), 64'd0);
        if (bus.done) dseen++;
        chk("abort.done_seen", 64'(dseen), 64'd0);
        run_op("abort_retry", 32'd3, 32'd7, 33, 64'd21);

        // Back-to-back: run_op leaves start low for exactly one cycle before the next rise.
        run_op("b2b_1", 32'h0001_0000, 32'h0001_0000, 33, 64'h0000_0001_0000_0000);
        run_op("b2b_2", 32'h1234_5678, 32'h0000_0010, 33, 64'h0000_0001_2345_6780);

        // Reset mid-BUSY with start held; release restarts a fresh op.
        bus.mul_src_data1 = 32'h0000_ABCD;
        bus.mul_src_data2 = 32'h0000_0100;
        bus.start         = 1'b1;
        repeat (15) @(negedge clk);
        chk("rstmid.busy_pre", 64'(bus.busy), 64'd1);
        @(posedge clk); #1;
        rstn = 1'b0;
        #1;
        chk("rstmid.done", 64'(bus.done), 64'd0);
        chk("rstmid.busy", 64'(bus.busy), 64'd0);
        chk("rstmid.prod", {bus.mul_result_hi, bus.mul_result_lo}, 64'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        run_op("rst_resume", 32'h0000_ABCD, 32'h0000_0100, 33, 64'h0000_0000_00AB_CD00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/mul_u.md
# mul_u

Unsigned iterative shift-add multiplier for the core's execute stage, the multiply counterpart to the unsigned divider. It takes two `DATA_WIDTH` operands under the same level-held `start` / `done` handshake the execute stage already uses for division. It produces the full 2×`DATA_WIDTH` product, low and high halves, for MUL/MULHU. The signed wrapper (MULH/MULHSU) sits above this block and handles sign fix-up.

## Interface
- `DATA_WIDTH`, default `` `DATA_WIDTH `` (32, from core_defines.vh): operand width.
- `D_DATA_WIDTH`, default `DATA_WIDTH*2`: product width.
- `CNT_WIDTH`, default 6: iteration counter width; must hold `DATA_WIDTH`.

Ports:
- `cpu_clk` in 1: CPU clock. One clock domain; all state on the rising edge.
- `cpu_rstn` in 1: asynchronous, active-low reset.
- `start` in 1: level request. The pipeline holds it high until it samples `done`.
- `done` out 1: product valid.
- `busy` out 1: iteration in progress.
- `mul_src_data1` in DATA_WIDTH: multiplicand. Stable while `start` is high.
- `mul_src_data2` in DATA_WIDTH: multiplier. Stable while `start` is high.
- `mul_result_lo` out DATA_WIDTH: product[DATA_WIDTH-1:0].
- `mul_result_hi` out DATA_WIDTH: product[D_DATA_WIDTH-1:DATA_WIDTH].

## Operation
- Registers:
  - `start_r`: `start` delayed one cycle.
  - `start_rising = start & ~start_r`.
  - FSM `state`.
  - `cnt`.
  - `acc`: D_DATA_WIDTH+1 bits, including the carry bit.
- FSM states:
  - IDLE
    - On `start_rising` and not fast-path: `acc <= {1'b0, DATA_WIDTH'0, mul_src_data2}`, `cnt <= 0`, go to BUSY.
    - Otherwise stay in IDLE.
  - BUSY, each cycle:
    - If `acc[0]`: `acc[D_DATA_WIDTH:DATA_WIDTH] <= acc[D_DATA_WIDTH-1:DATA_WIDTH] + mul_src_data1`, as a DATA_WIDTH+1 bit sum.
    - Then the whole `acc` shifts right one bit, zero fill from the top, as one registered update.
    - `cnt <= cnt+1`.
    - When `cnt == DATA_WIDTH-1`, go to DONE.
    - If `start` is low, go to IDLE (abort).
  - DONE: hold `acc`. When `start` is low, go to IDLE.
- Outputs:
  - `done = (state==DONE) | fastpath_hit`.
  - `busy = (state==BUSY)`.
  - Results come from `acc[D_DATA_WIDTH-1:0]` in DONE, from the fast path when `fastpath_hit`, and are 0 otherwise.
- Arithmetic: a modulo-2^D_DATA_WIDTH product is never needed, because the product always fits in D_DATA_WIDTH. The carry bit absorbs the add overflow before the shift.
- Leaving DONE or aborting clears `acc` to 0.

## Timing
- Reset values:
  - `done` = 0, `busy` = 0.
  - `mul_result_lo` = 0, `mul_result_hi` = 0.
  - `state` = IDLE, `cnt` = 0, `acc` = 0, `start_r` = 0.
- Latency (multi-cycle path):
  - `start` is first high in cycle 0.
  - BUSY covers cycles 1..DATA_WIDTH.
  - `done` rises in cycle DATA_WIDTH+1 (33 for 32-bit) and stays high while `start` is high.
- Handshake:
  - The pipeline drops `start` in the cycle after sampling `done`. `done` falls in the next cycle.
  - A new operation requires `start` low for at least one cycle; back-to-back ops are separated by one idle cycle.
- Abort: `start` low during BUSY gives IDLE on the next edge. `done` never pulses and results stay 0.
- Reset mid-operation: immediate return to reset values. There is no resumption.
- Operand change while BUSY is illegal. The result is undefined but the FSM still completes.

## Configuration
- `MUL_U_FAST_PATH_EN` defined:
  - `fastpath_hit = start & (src1==0 | src2==0 | src1==1 | src2==1)`.
  - When it hits, `done` is high in the same cycle as `start`. No register stage is involved.
  - Result is 0 if either operand is 0; otherwise it is the other operand zero-extended to D_DATA_WIDTH.
  - The FSM stays in IDLE.
- Not defined:
  - `fastpath_hit` is tied to 0.
  - Every operation takes the full DATA_WIDTH+1 cycle latency, including operands of 0 and 1.

## Test plan
- Reset: `cpu_rstn` low mid-BUSY → `done`, `busy`, results all 0 asynchronously; `start` held after release → fresh operation completes normally.
- Basic: 0x0000_1234 × 0x0000_5678, `start` held → `done` in cycle 33, lo = 0x0626_0060, hi = 0x0000_0000, `busy` high for exactly 32 cycles.
- Full-width carry: 0xFFFF_FFFF × 0xFFFF_FFFF → hi = 0xFFFF_FFFE, lo = 0x0000_0001.
- Fast path:
  - With the macro: 0x0 × 0xDEAD_BEEF → `done` in cycle 0, product 0.
  - With the macro: 0x1 × 0x8000_0000 → `done` in cycle 0, lo = 0x8000_0000.
  - Without the macro: both cases → `done` in cycle 33 with the same values.
- Abort: drop `start` in cycle 10 → `busy` low in cycle 11, `done` never asserts. Re-raise `start` with 3 × 7 → lo = 21 after 33 cycles.
- Back-to-back: two ops separated by a one-cycle `start` low → second `done` 33 cycles after the second rise, with a correct independent product.
